// File: rtl/intra_4x4_mode_sel.sv
// Intra 4x4 mode selector: walks the 16 luma sub-blocks of one MB in decode order, picks
// V/H/DC by SAD, emits the residual and refreshes top/left neighbours from the reconstruction.
module intra_4x4_mode_sel #(
  parameter int         PIX_W     = 8,
  parameter int         MAX_WIDTH = 1280,
  parameter logic [2:0] MODE_EN   = 3'b111
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         h264_reset,
  input  logic                         mb_valid,
  output logic                         mb_ready,
  input  logic [6:0]                   mb_x,
  input  logic [6:0]                   mb_y,
  input  logic [15:0][15:0][PIX_W-1:0] mb_pix,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [3:0][3:0][PIX_W:0]     res_blk,
  output logic [1:0]                   res_mode,
  output logic [3:0]                   res_idx,
  output logic [10:0]                  topleft_x,
  output logic [10:0]                  topleft_y,
  input  logic                         rec_valid,
  input  logic [3:0][3:0][PIX_W-1:0]   rec_blk,
  output logic                         mb_done
);
  localparam int AW   = $clog2(MAX_WIDTH);
  localparam int SW   = PIX_W + 4;
  localparam int SUMW = PIX_W + 2;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0, S_LOAD = 4'd1, S_ADDR = 4'd2, S_FETCH = 4'd3, S_EVAL = 4'd4,
    S_SELECT = 4'd5, S_OUT = 4'd6, S_WAIT_REC = 4'd7, S_DONE = 4'd8
  } state_t;

  state_t                       r_state;
  logic [6:0]                   r_mb_x, r_mb_y;
  logic [15:0][15:0][PIX_W-1:0] r_pix;
  logic [3:0]                   r_idx;
  logic [10:0]                  r_tl_x, r_tl_y;
  logic [3:0][3:0][PIX_W-1:0]   r_src;
  logic [3:0][PIX_W-1:0]        r_t, r_l;
  logic                         r_top_av, r_left_av;
  logic [2:0]                   r_pend;
  logic [1:0]                   r_best_mode;
  logic [SW-1:0]                r_best_sad;
  logic [PIX_W-1:0]             r_tp [MAX_WIDTH];
  logic [PIX_W-1:0]             r_lp [16];

  logic                         w_srst;
  logic [3:0]                   w_x_off, w_y_off;
  logic [1:0]                   w_mode;
  logic [2:0]                   w_mode_bit, w_cand;
  logic [SUMW-1:0]              w_sum_t, w_sum_l, w_half_t, w_half_l;
  logic [SUMW:0]                w_sum_tl;
  logic [PIX_W-1:0]             w_dc;
  logic [SW-1:0]                w_sad;
  logic [3:0][3:0][PIX_W-1:0]   w_pred_cur, w_pred_best;
  logic [3:0][3:0][PIX_W:0]     w_res;

  function automatic logic [3:0][3:0][PIX_W-1:0] pred_blk(
    input logic [1:0] mode, input logic [3:0][PIX_W-1:0] t,
    input logic [3:0][PIX_W-1:0] l, input logic [PIX_W-1:0] dc);
    logic [3:0][3:0][PIX_W-1:0] p;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        case (mode)
          2'd0:    p[r][c] = t[c];
          2'd1:    p[r][c] = l[r];
          default: p[r][c] = dc;
        endcase
      end
    end
    return p;
  endfunction

  function automatic logic [SW-1:0] sad_blk(
    input logic [3:0][3:0][PIX_W-1:0] s, input logic [3:0][3:0][PIX_W-1:0] p);
    logic [SW-1:0] acc;
    acc = {SW{1'b0}};
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        acc = acc + SW'((s[r][c] > p[r][c]) ? (s[r][c] - p[r][c]) : (p[r][c] - s[r][c]));
      end
    end
    return acc;
  endfunction

  assign w_srst  = rst | h264_reset;
  assign w_x_off = {r_idx[2], r_idx[0], 2'b00};
  assign w_y_off = {r_idx[3], r_idx[1], 2'b00};
  assign w_cand  = MODE_EN & {1'b1, (r_tl_x != 11'd0), (r_tl_y != 11'd0)};
  assign w_mode  = r_pend[0] ? 2'd0 : (r_pend[1] ? 2'd1 : 2'd2);
  assign w_mode_bit = 3'b001 << w_mode;

  assign topleft_x = r_tl_x;
  assign topleft_y = r_tl_y;

  // DC predictor from whichever neighbours are positionally available
  always_comb begin
    w_sum_t = {SUMW{1'b0}};
    w_sum_l = {SUMW{1'b0}};
    for (int k = 0; k < 4; k++) begin
      w_sum_t = w_sum_t + SUMW'(r_t[k]);
      w_sum_l = w_sum_l + SUMW'(r_l[k]);
    end
    w_sum_tl = {1'b0, w_sum_t} + {1'b0, w_sum_l} + {{PIX_W{1'b0}}, 3'd4};
    w_half_t = w_sum_t + {{PIX_W{1'b0}}, 2'd2};
    w_half_l = w_sum_l + {{PIX_W{1'b0}}, 2'd2};
    if (r_top_av && r_left_av) begin
      w_dc = w_sum_tl[SUMW:3];
    end else if (r_top_av) begin
      w_dc = w_half_t[SUMW-1:2];
    end else if (r_left_av) begin
      w_dc = w_half_l[SUMW-1:2];
    end else begin
      w_dc = {1'b1, {(PIX_W-1){1'b0}}};
    end
  end

  // Prediction, SAD of the mode under evaluation and residual of the winner
  always_comb begin
    w_pred_cur  = pred_blk(w_mode, r_t, r_l, w_dc);
    w_pred_best = pred_blk(r_best_mode, r_t, r_l, w_dc);
    w_sad       = sad_blk(r_src, w_pred_cur);
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        w_res[r][c] = {1'b0, r_src[r][c]} - {1'b0, w_pred_best[r][c]};
      end
    end
  end

  // Block sequencer: control state plus all datapath and output registers
  always_ff @(posedge clk) begin
    if (w_srst) begin
      r_state     <= S_IDLE;
      mb_ready    <= 1'b1;
      res_valid   <= 1'b0;
      res_blk     <= '0;
      res_mode    <= 2'd0;
      res_idx     <= 4'd0;
      mb_done     <= 1'b0;
      r_mb_x      <= 7'd0;
      r_mb_y      <= 7'd0;
      r_pix       <= '0;
      r_idx       <= 4'd0;
      r_tl_x      <= 11'd0;
      r_tl_y      <= 11'd0;
      r_src       <= '0;
      r_t         <= '0;
      r_l         <= '0;
      r_top_av    <= 1'b0;
      r_left_av   <= 1'b0;
      r_pend      <= 3'b000;
      r_best_mode <= 2'd2;
      r_best_sad  <= {SW{1'b1}};
    end else begin
      case (r_state)
        S_IDLE: begin
          if (mb_valid) begin
            r_mb_x   <= mb_x;
            r_mb_y   <= mb_y;
            r_pix    <= mb_pix;
            r_idx    <= 4'd0;
            mb_ready <= 1'b0;
            r_state  <= S_LOAD;
          end
        end
        S_LOAD: r_state <= S_ADDR;
        S_ADDR: begin
          r_tl_x  <= {r_mb_x, 4'd0} + {7'd0, w_x_off};
          r_tl_y  <= {r_mb_y, 4'd0} + {7'd0, w_y_off};
          r_state <= S_FETCH;
        end
        S_FETCH: begin
          for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
              r_src[r][c] <= r_pix[w_y_off + 4'(r)][w_x_off + 4'(c)];
            end
          end
          for (int k = 0; k < 4; k++) begin
            r_t[k] <= r_tp[AW'(r_tl_x + 11'(k))];
            r_l[k] <= r_lp[w_y_off + 4'(k)];
          end
          r_top_av    <= (r_tl_y != 11'd0);
          r_left_av   <= (r_tl_x != 11'd0);
          r_pend      <= (w_cand == 3'b000) ? 3'b100 : w_cand;
          r_best_mode <= 2'd2;
          r_best_sad  <= {SW{1'b1}};
          r_state     <= S_EVAL;
        end
        S_EVAL: begin
          // strict compare keeps the lower-numbered mode on a tie
          if (w_sad < r_best_sad) begin
            r_best_sad  <= w_sad;
            r_best_mode <= w_mode;
          end
          r_pend <= r_pend & ~w_mode_bit;
          if ((r_pend & ~w_mode_bit) == 3'b000) begin
            r_state <= S_SELECT;
          end
        end
        S_SELECT: begin
          res_blk   <= w_res;
          res_mode  <= r_best_mode;
          res_idx   <= r_idx;
          res_valid <= 1'b1;
          r_state   <= S_OUT;
        end
        S_OUT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            r_state   <= S_WAIT_REC;
          end
        end
        S_WAIT_REC: begin
          if (rec_valid) begin
            if (r_idx == 4'd15) begin
              mb_done <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_idx   <= r_idx + 4'd1;
              r_state <= S_ADDR;
            end
          end
        end
        S_DONE: begin
          mb_done  <= 1'b0;
          mb_ready <= 1'b1;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Neighbour buffers take the reconstructed bottom row / right column; never cleared
  always_ff @(posedge clk) begin
    if (!w_srst && (r_state == S_WAIT_REC) && rec_valid) begin
      for (int k = 0; k < 4; k++) begin
        r_tp[AW'(r_tl_x + 11'(k))] <= rec_blk[3][k];
        r_lp[w_y_off + 4'(k)]      <= rec_blk[k][3];
      end
    end
  end
endmodule

// File: tb/tb_intra_4x4_mode_sel.sv
// Self-checking bench for intra_4x4_mode_sel: frame-level neighbour model, directed MBs,
// stall, mid-block soft reset and a second instance restricted to Vertical only.
module tb_intra_4x4_mode_sel;
  localparam int PW = 8;
  typedef logic [15:0][15:0][PW-1:0] pix_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, h264_reset, mb_valid, mb_ready, res_valid, res_ready, rec_valid, mb_done;
  logic [6:0] mb_x, mb_y;
  pix_t mb_pix;
  logic [3:0][3:0][PW:0] res_blk;
  logic [1:0] res_mode;
  logic [3:0] res_idx;
  logic [10:0] topleft_x, topleft_y;
  logic [3:0][3:0][PW-1:0] rec_blk;

  logic mb_valid1, mb_ready1, res_valid1, res_ready1, mb_done1;
  logic [3:0][3:0][PW:0] res_blk1;
  logic [1:0] res_mode1;
  logic [3:0] res_idx1;
  logic [10:0] topleft_x1, topleft_y1;

  intra_4x4_mode_sel #(.PIX_W(PW), .MAX_WIDTH(1280), .MODE_EN(3'b111)) u_dut (
    .clk(clk), .rst(rst), .h264_reset(h264_reset), .mb_valid(mb_valid), .mb_ready(mb_ready),
    .mb_x(mb_x), .mb_y(mb_y), .mb_pix(mb_pix), .res_valid(res_valid), .res_ready(res_ready),
    .res_blk(res_blk), .res_mode(res_mode), .res_idx(res_idx), .topleft_x(topleft_x),
    .topleft_y(topleft_y), .rec_valid(rec_valid), .rec_blk(rec_blk), .mb_done(mb_done));

  intra_4x4_mode_sel #(.PIX_W(PW), .MAX_WIDTH(1280), .MODE_EN(3'b001)) u_dut_v (
    .clk(clk), .rst(rst), .h264_reset(h264_reset), .mb_valid(mb_valid1), .mb_ready(mb_ready1),
    .mb_x(mb_x), .mb_y(mb_y), .mb_pix(mb_pix), .res_valid(res_valid1), .res_ready(res_ready1),
    .res_blk(res_blk1), .res_mode(res_mode1), .res_idx(res_idx1), .topleft_x(topleft_x1),
    .topleft_y(topleft_y1), .rec_valid(rec_valid), .rec_blk(rec_blk), .mb_done(mb_done1));

  int errors = 0;
  int checks = 0;
  int m_tp [0:1279];
  int m_lp [0:15];
  int e_mode, e_tlx, e_tly, e_xo, e_yo;
  int e_res [4][4];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Frame-level model: neighbours from the model buffers, every permitted mode scored, min wins
  task automatic model_block(input int mbx, input int mby, input int b, input pix_t src,
                             input bit [2:0] en);
    int t[4], l[4];
    int st, sl, dc, best, sad, p;
    bit tav, lav;
    bit [2:0] ok;
    e_xo = ((b >> 2) & 1) * 8 + (b & 1) * 4;
    e_yo = ((b >> 3) & 1) * 8 + ((b >> 1) & 1) * 4;
    e_tlx = mbx * 16 + e_xo;
    e_tly = mby * 16 + e_yo;
    tav = (e_tly != 0);
    lav = (e_tlx != 0);
    st = 0; sl = 0;
    for (int k = 0; k < 4; k++) begin
      t[k] = m_tp[e_tlx + k];
      l[k] = m_lp[e_yo + k];
      st += t[k];
      sl += l[k];
    end
    if (tav && lav) dc = (st + sl + 4) / 8;
    else if (tav) dc = (st + 2) / 4;
    else if (lav) dc = (sl + 2) / 4;
    else dc = 128;
    ok = en & {1'b1, lav, tav};
    if (ok == 3'b000) ok = 3'b100;
    best = 1 << 30;
    e_mode = -1;
    for (int m = 0; m < 3; m++) begin
      if (ok[m]) begin
        sad = 0;
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 4; c++) begin
            p = (m == 0) ? t[c] : ((m == 1) ? l[r] : dc);
            sad += (int'(src[e_yo + r][e_xo + c]) > p) ? int'(src[e_yo + r][e_xo + c]) - p
                                                       : p - int'(src[e_yo + r][e_xo + c]);
          end
        if (sad < best) begin
          best = sad;
          e_mode = m;
        end
      end
    end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        p = (e_mode == 0) ? t[c] : ((e_mode == 1) ? l[r] : dc);
        e_res[r][c] = int'(src[e_yo + r][e_xo + c]) - p;
      end
  endtask

  task automatic check_out(input string tag, input int b);
    bit bad;
    int ar, er;
    bad = 1'b0; ar = 0; er = 0;
    chk({tag, "_valid"}, res_valid, 1);
    chk({tag, "_idx"}, res_idx, b);
    chk({tag, "_mode"}, res_mode, e_mode);
    chk({tag, "_tlx"}, topleft_x, e_tlx);
    chk({tag, "_tly"}, topleft_y, e_tly);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!bad && int'($signed(res_blk[r][c])) != e_res[r][c]) begin
          bad = 1'b1;
          ar = int'($signed(res_blk[r][c]));
          er = e_res[r][c];
        end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL %s_res blk %0d: got %0d expected %0d", tag, b, ar, er);
    end
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (res_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL res_valid_timeout: got 0 expected 1");
    end
  endtask

  // One MB through the DUT; pin selects hand-computed literals, abort_blk triggers h264_reset
  task automatic run_mb(input int mbx, input int mby, input pix_t src, input bit rec_const,
                        input int rec_val, input int stall_blk, input int abort_blk, input int pin);
    bit ok;
    @(negedge clk);
    chk("mb_ready_idle", mb_ready, 1);
    mb_x = 7'(mbx); mb_y = 7'(mby); mb_pix = src; mb_valid = 1'b1;
    @(negedge clk);
    mb_valid = 1'b0;
    chk("mb_ready_busy", mb_ready, 0);
    for (int b = 0; b < 16; b++) begin
      wait_valid(ok);
      if (!ok) return;
      model_block(mbx, mby, b, src, 3'b111);
      check_out("out", b);
      if (pin == 1 && b == 0) begin
        chk("t1_b0_model_mode", e_mode, 2);
        chk("t1_b0_model_res", e_res[0][0], -28);
        chk("t1_b0_dut_res", int'($signed(res_blk[0][0])), -28);
      end
      if (pin == 1 && b == 1) begin
        chk("t1_b1_model_mode", e_mode, 1);
        chk("t1_b1_model_res", e_res[2][3], 0);
        chk("t1_b1_dut_res", int'($signed(res_blk[2][3])), 0);
      end
      if (pin == 2 && b == 0) begin
        chk("t2_b0_model_mode", e_mode, 1);
        chk("t2_b0_model_res00", e_res[0][0], -50);
        chk("t2_b0_model_res03", e_res[0][3], -20);
        chk("t2_b0_dut_mode", res_mode, 1);
      end
      if (pin == 3 && b == 0) begin
        chk("t3_b0_model_mode", e_mode, 0);
        chk("t3_b0_dut_mode", res_mode, 0);
        chk("t3_b0_dut_res", int'($signed(res_blk[1][1])), 0);
      end
      if (b == stall_blk) begin
        repeat (20) begin
          @(negedge clk);
          check_out("stall", b);
          chk("stall_mb_ready", mb_ready, 0);
        end
      end
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      chk("res_valid_drop", res_valid, 0);
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          rec_blk[r][c] = rec_const ? 8'(rec_val) : src[e_yo + r][e_xo + c];
      for (int k = 0; k < 4; k++) begin
        m_tp[e_tlx + k] = int'(rec_blk[3][k]);
        m_lp[e_yo + k]  = int'(rec_blk[k][3]);
      end
      rec_valid = 1'b1;
      @(negedge clk);
      rec_valid = 1'b0;
      chk("mb_done", mb_done, (b == 15) ? 1 : 0);
      if (b + 1 == abort_blk) begin
        @(negedge clk);
        @(negedge clk);
        h264_reset = 1'b1;
        @(negedge clk);
        h264_reset = 1'b0;
        chk("abort_mb_ready", mb_ready, 1);
        chk("abort_res_valid", res_valid, 0);
        chk("abort_mb_done", mb_done, 0);
        repeat (10) begin
          @(negedge clk);
          chk("abort_quiet_done", mb_done, 0);
          chk("abort_quiet_valid", res_valid, 0);
        end
        return;
      end
    end
    @(negedge clk);
    chk("mb_done_pulse_end", mb_done, 0);
    chk("mb_ready_back", mb_ready, 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    pix_t src100, src200, srccol;
    bit ok;
    rst = 1'b1; h264_reset = 1'b0; mb_valid = 1'b0; mb_valid1 = 1'b0;
    res_ready = 1'b0; res_ready1 = 1'b0; rec_valid = 1'b0;
    mb_x = 7'd0; mb_y = 7'd0; mb_pix = '0; rec_blk = '0;
    for (int i = 0; i < 1280; i++) m_tp[i] = 0;
    for (int i = 0; i < 16; i++) m_lp[i] = 0;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) begin
        src100[r][c] = 8'd100;
        src200[r][c] = 8'd200;
        srccol[r][c] = 8'(c * 10);
      end
    repeat (3) @(negedge clk);
    chk("rst_mb_ready", mb_ready, 1);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_mb_done", mb_done, 0);
    chk("rst_res_idx", res_idx, 0);
    chk("rst_res_mode", res_mode, 0);
    chk("rst_topleft_x", topleft_x, 0);
    chk("rst_mb_ready_v", mb_ready1, 1);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_mb_ready", mb_ready, 1);

    run_mb(0, 0, src100, 1'b0, 0, -1, -1, 1);
    run_mb(0, 0, src100, 1'b1, 50, -1, -1, 0);
    run_mb(1, 0, srccol, 1'b0, 0, 3, -1, 2);
    run_mb(0, 0, src100, 1'b1, 200, -1, -1, 0);
    run_mb(0, 1, src200, 1'b0, 0, -1, -1, 3);
    run_mb(0, 0, src100, 1'b0, 0, -1, 7, 0);
    run_mb(0, 0, src100, 1'b0, 0, -1, -1, 0);

    // Vertical-only instance: block 0 has no top, so DC is forced
    @(negedge clk);
    mb_x = 7'd0; mb_y = 7'd0; mb_pix = src100; mb_valid1 = 1'b1;
    @(negedge clk);
    mb_valid1 = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (res_valid1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("t4_res_valid", res_valid1, 1);
    model_block(0, 0, 0, src100, 3'b001);
    chk("t4_model_mode", e_mode, 2);
    chk("t4_mode", res_mode1, 2);
    chk("t4_res00", int'($signed(res_blk1[0][0])), -28);
    chk("t4_idx", res_idx1, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t4_rst_ready", mb_ready1, 1);
    chk("t4_rst_valid", res_valid1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
